// File: rtl/spi_receive_con.sv
// Multi-line SPI receiver: synchronizes raw clk/cs/data, shifts LINES words MSB first.
// Optional SPI_RX_ERR_COUNT_EN adds a saturating 8-bit aborted-word counter (err_count_out).
module spi_receive_con #(
    parameter int DATA_WIDTH = 16,
    parameter int LINES      = 6
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [LINES-1:0]              chip_data_in,
    input  logic                          chip_clk_in,
    input  logic                          chip_sel_in,
    output logic [LINES*DATA_WIDTH-1:0]   data_out,
    output logic                          data_valid_out,
    output logic                          error_out
`ifdef SPI_RX_ERR_COUNT_EN
    ,
    output logic [7:0]                    err_count_out
`endif
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, RECEIVE} state_t;

    logic                                r_clk_s1, r_clk_s2, r_clk_s3;
    logic                                r_cs_s1, r_cs_s2, r_cs_s3;
    logic [LINES-1:0]                    r_dat_s1, r_dat_s2;
    logic                                r_clk_rise, r_cs_rise, r_cs_fall;
    logic [LINES-1:0]                    r_bits;
    state_t                              r_state;
    logic [CW-1:0]                       r_cnt;
    logic [LINES-1:0][DATA_WIDTH-1:0]    r_shift;
    logic                                r_word_done;
    logic                                w_last_bit;

    // Identical synchronizer depth on clk, cs and data keeps them delay-matched;
    // the third clk/cs stage is only the previous value for edge detection.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_clk_s3   <= 1'b0;
            r_cs_s1    <= 1'b1;
            r_cs_s2    <= 1'b1;
            r_cs_s3    <= 1'b1;
            r_dat_s1   <= '0;
            r_dat_s2   <= '0;
            r_clk_rise <= 1'b0;
            r_cs_rise  <= 1'b0;
            r_cs_fall  <= 1'b0;
            r_bits     <= '0;
        end else begin
            r_clk_s1   <= chip_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_s3   <= r_clk_s2;
            r_cs_s1    <= chip_sel_in;
            r_cs_s2    <= r_cs_s1;
            r_cs_s3    <= r_cs_s2;
            r_dat_s1   <= chip_data_in;
            r_dat_s2   <= r_dat_s1;
            r_clk_rise <= r_clk_s2 & ~r_clk_s3;
            r_cs_rise  <= r_cs_s2 & ~r_cs_s3;
            r_cs_fall  <= ~r_cs_s2 & r_cs_s3;
            r_bits     <= r_dat_s2;
        end
    end

    assign w_last_bit = r_clk_rise && (r_cnt == LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_word_done <= 1'b0;
            error_out   <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            error_out   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_cs_fall) begin
                        r_state <= RECEIVE;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                RECEIVE: begin
                    if (r_clk_rise) begin
                        for (int i = 0; i < LINES; i++)
                            r_shift[i] <= {r_shift[i][DATA_WIDTH-2:0], r_bits[i]};
                        r_cnt       <= w_last_bit ? '0 : r_cnt + 1'b1;
                        r_word_done <= w_last_bit;
                    end
                    // A word completing on the same cycle as cs rising is not an abort.
                    if (r_cs_rise) begin
                        r_state <= IDLE;
                        if (r_cnt != '0 && !w_last_bit)
                            error_out <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_out       <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= r_word_done;
            if (r_word_done)
                data_out <= r_shift;
        end
    end

`ifdef SPI_RX_ERR_COUNT_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            err_count_out <= 8'd0;
        else if (error_out && err_count_out != 8'hFF)
            err_count_out <= err_count_out + 8'd1;
    end
`endif

endmodule

// File: tb/tb_spi_receive_con.sv
// Directed bench for spi_receive_con: single word, back-to-back, abort, simultaneity, reset.
// Also checks err_count_out when SPI_RX_ERR_COUNT_EN is defined.
module tb_spi_receive_con;

    localparam int DW = 16;
    localparam int NL = 6;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic [NL-1:0]     chip_data_in = '0;
    logic              chip_clk_in = 1'b0;
    logic              chip_sel_in = 1'b1;
    logic [NL*DW-1:0]  data_out;
    logic              data_valid_out;
    logic              error_out;
`ifdef SPI_RX_ERR_COUNT_EN
    logic [7:0]        err_count_out;
`endif

    spi_receive_con #(.DATA_WIDTH(DW), .LINES(NL)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .chip_data_in   (chip_data_in),
        .chip_clk_in    (chip_clk_in),
        .chip_sel_in    (chip_sel_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .error_out      (error_out)
`ifdef SPI_RX_ERR_COUNT_EN
        ,
        .err_count_out  (err_count_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_err = 0;

    always @(negedge clk_in) begin
        if (data_valid_out) n_valid++;
        if (error_out)      n_err++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shift nbits of each line's word, MSB first, at dclk = clk_in/6.
    task automatic send_bits(input logic [DW-1:0] w [NL], input int nbits,
                             input bit lat_chk, input bit cs_on_last);
        for (int b = 0; b < nbits; b++) begin
            chip_clk_in = 1'b0;
            for (int l = 0; l < NL; l++) chip_data_in[l] = w[l][DW-1-b];
            repeat (3) @(negedge clk_in);
            chip_clk_in = 1'b1;
            if (b == nbits - 1 && cs_on_last) chip_sel_in = 1'b1;
            if (b == nbits - 1 && lat_chk) begin
                @(posedge clk_in);
                repeat (3) @(posedge clk_in);
                #1 chk("valid_early", data_valid_out, 1'b0);
                @(posedge clk_in);
                #1 chk("valid_lat4", data_valid_out, 1'b1);
                @(negedge clk_in);
            end else begin
                repeat (3) @(negedge clk_in);
            end
        end
        chip_clk_in = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic chk_word(input string tag, input logic [DW-1:0] w [NL]);
        for (int l = 0; l < NL; l++)
            chk(tag, data_out[l*DW +: DW], w[l]);
    endtask

    logic [DW-1:0] wa [NL];
    logic [DW-1:0] wb [NL];
    logic [DW-1:0] wc [NL];
    logic [DW-1:0] we [NL];
    logic [DW-1:0] wf [NL];
    int v0, e0;

    initial begin
        wa = '{16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'h0000};
        wb = '{16'h1111, 16'h2222, 16'h4444, 16'h8888, 16'hF0F0, 16'h0F0F};
        wc = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h5A5A, 16'h0000, 16'hFFFF};
        we = '{16'h7E81, 16'h0102, 16'h8001, 16'h3C3C, 16'hAAAA, 16'h5555};
        wf = '{16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978, 16'h8796, 16'hA5B4};

        repeat (3) @(negedge clk_in);
        chk("rst_data", data_out, '0);
        chk("rst_valid", data_valid_out, 1'b0);
        chk("rst_err", error_out, 1'b0);
`ifdef SPI_RX_ERR_COUNT_EN
        chk("rst_errcnt", err_count_out, 8'd0);
`endif
        rst_in = 1'b0;
        repeat (4) @(negedge clk_in);

        // Single word
        chip_sel_in = 1'b0;
        repeat (4) @(negedge clk_in);
        send_bits(wa, DW, 1'b1, 1'b0);
        chip_sel_in = 1'b1;
        repeat (8) @(negedge clk_in);
        chk("single_nvalid", n_valid, 1);
        chk("single_nerr", n_err, 0);
        chk_word("single_data", wa);

        // Back-to-back under one cs
        chip_sel_in = 1'b0;
        repeat (4) @(negedge clk_in);
        send_bits(wb, DW, 1'b1, 1'b0);
        chk_word("b2b_first", wb);
        send_bits(wc, DW, 1'b1, 1'b0);
        chip_sel_in = 1'b1;
        repeat (8) @(negedge clk_in);
        chk("b2b_nvalid", n_valid, 3);
        chk("b2b_nerr", n_err, 0);
        chk_word("b2b_second", wc);

        // Abort after 9 bits
        chip_sel_in = 1'b0;
        repeat (4) @(negedge clk_in);
        send_bits(we, 9, 1'b0, 1'b0);
        chip_sel_in = 1'b1;
        repeat (8) @(negedge clk_in);
        chk("abort_nerr", n_err, 1);
        chk("abort_nvalid", n_valid, 3);
        chk_word("abort_hold", wc);
`ifdef SPI_RX_ERR_COUNT_EN
        chk("abort_errcnt", err_count_out, 8'd1);
`endif

        // Last dclk rise and cs rise on the same edge
        chip_sel_in = 1'b0;
        repeat (4) @(negedge clk_in);
        send_bits(we, DW, 1'b1, 1'b1);
        repeat (8) @(negedge clk_in);
        chk("simul_nvalid", n_valid, 4);
        chk("simul_nerr", n_err, 1);
        chk_word("simul_data", we);

        // Reset mid-word, idle dclk ignored, then a fresh word
        chip_sel_in = 1'b0;
        repeat (4) @(negedge clk_in);
        send_bits(wf, 5, 1'b0, 1'b0);
        rst_in = 1'b1;
        #1;
        chk("midrst_data", data_out, '0);
        chk("midrst_valid", data_valid_out, 1'b0);
        chk("midrst_err", error_out, 1'b0);
        chip_sel_in = 1'b1;
        repeat (4) @(negedge clk_in);
        rst_in = 1'b0;
        v0 = n_valid;
        e0 = n_err;
        send_bits(wa, 4, 1'b0, 1'b0);
        repeat (8) @(negedge clk_in);
        chk("idle_nvalid", n_valid, v0);
        chk("idle_data", data_out, '0);
        chip_sel_in = 1'b0;
        repeat (4) @(negedge clk_in);
        send_bits(wf, DW, 1'b1, 1'b0);
        chip_sel_in = 1'b1;
        repeat (8) @(negedge clk_in);
        chk("postrst_nvalid", n_valid, v0 + 1);
        chk("postrst_nerr", n_err, e0);
        chk_word("postrst_data", wf);

`ifdef SPI_RX_ERR_COUNT_EN
        // Saturation: 300 aborted words
        for (int k = 0; k < 300; k++) begin
            chip_sel_in = 1'b0;
            repeat (4) @(negedge clk_in);
            send_bits(wa, 1, 1'b0, 1'b0);
            chip_sel_in = 1'b1;
            repeat (6) @(negedge clk_in);
        end
        chk("sat_errcnt", err_count_out, 8'd255);
        chk("sat_nerr", n_err, e0 + 300);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_receive_con.md
SPI_RECEIVE_CON -- requirements
Module: spi_receive_con

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving bits per line per word.
REQ-002 The block SHALL have parameter LINES, default 6, giving the number of parallel data lines.
REQ-003 Port clk_in, input, 1: the block's single clock, 100 MHz; one clock; reset is asynchronous and active-high.
REQ-004 Port rst_in, input, 1: asynchronous active-high reset.
REQ-005 Port chip_data_in, input, LINES: raw serial data, one bit per line, asynchronous to clk_in.
REQ-006 Port chip_clk_in, input, 1: raw SPI data clock, asynchronous, at most clk_in/4.
REQ-007 Port chip_sel_in, input, 1: raw chip select, active-low, asynchronous.
REQ-008 Port data_out, output, LINES*DATA_WIDTH: received word; line i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port data_valid_out, output, 1: single-cycle pulse; data_out is valid in this cycle.
REQ-010 Port error_out, output, 1: single-cycle pulse marking a word aborted mid-transfer.

Function
REQ-011 The block SHALL pass chip_clk_in, chip_sel_in and chip_data_in through identical 2-flop synchronizers, so the three stay delay-matched.
REQ-012 A rising edge SHALL be detected when the synchronized clock is 1 and its previous registered value is 0.
REQ-013 Data SHALL be sampled on rising edges only, MSB first, from the synchronized data stage aligned with the detecting clock stage.
REQ-014 The state machine SHALL have two states: IDLE while synchronized chip_sel is high, and RECEIVE while it is low.
REQ-015 IDLE->RECEIVE SHALL occur on the synchronized falling edge of chip_sel; this transition SHALL clear the bit counter and the shift registers.
REQ-016 In RECEIVE, each rising edge SHALL shift one bit into each of LINES shift registers and increment a bit counter of width $clog2(DATA_WIDTH).
REQ-017 On the edge that carries bit DATA_WIDTH-1, the block SHALL, in the next cycle, register all shift registers into data_out and pulse data_valid_out for one cycle.
REQ-018 The same edge SHALL wrap the bit counter to 0, so back-to-back words under one chip_sel assertion are supported.
REQ-019 Latency SHALL be exactly 4 clk_in cycles from the clk_in edge that first registers the raw last-bit chip_clk_in high to data_valid_out high.
REQ-020 data_out SHALL hold its value between pulses.
REQ-021 RECEIVE->IDLE SHALL occur on the synchronized rising edge of chip_sel.
REQ-022 If the bit counter is nonzero when chip_sel rises, the partial word SHALL be discarded, error_out SHALL pulse once, and data_out SHALL be unchanged.
REQ-023 If the bit counter is 0 when chip_sel rises, there SHALL be no error pulse.
REQ-024 When a last-bit edge and a chip_sel rise are detected in the same cycle, the word SHALL complete normally with a valid pulse and no error pulse.
REQ-025 Rising edges of chip_clk_in while in IDLE SHALL be ignored.

Reset
REQ-026 rst_in high SHALL immediately force state to IDLE and clear the bit counter, the shift registers, data_out, data_valid_out and error_out to 0.
REQ-027 rst_in high SHALL initialize the synchronizer stages to chip_sel=1, clk=0 and data=0.
REQ-028 rst_in asserted mid-word SHALL discard that word with no error pulse.
REQ-029 After rst_in is released, reception SHALL resume only after a fresh chip_sel falling edge.

Configuration
REQ-030 With macro SPI_RX_ERR_COUNT_EN defined, the block SHALL add output port err_count_out (8 bits, reset 0).
REQ-031 err_count_out SHALL increment on each error_out pulse and saturate at 255.
REQ-032 Without SPI_RX_ERR_COUNT_EN, err_count_out and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Single word: cs low, lines 0..5 send 16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'h0000 at dclk=clk_in/6 -> one valid pulse, 4 cycles after the last edge, with matching data_out slices.
REQ-034 Back-to-back: 2 words under one cs assertion -> 2 valid pulses, the second carrying the second word, and no error.
REQ-035 Abort: cs rises after 9 bits -> error_out pulses once, no valid pulse, data_out retains the prior word; with the macro, err_count_out=1.
REQ-036 Simultaneity: last dclk rise and cs rise on the same clk_in edge -> valid pulse, no error.
REQ-037 Reset mid-word: rst_in after 5 bits, then a full word -> only the full word is reported, no error pulse, and all outputs read 0 during reset.
REQ-038 Saturation (macro defined): 300 aborted words -> err_count_out=255.
